modulation_unroll_mapper: RTL and testbench

- Parametrised successor to the fixed 10-segment if/else modulation unroll.
- Maps one input bit word onto NUM_SEG signed fixed-point segments of +amp or -amp, with a per-segment polarity mask.
- Adds a differential (DBPSK) mode whose phase state carries across words, a runtime amplitude, valid/ready handshakes on both sides, and an accepted-word counter.
- Sits between the bit source and the downstream segment consumers (correlator/accumulator) in the Modulation_Unroll datapath.

---
 rtl/modulation_pkg.sv | 17 +
 rtl/modulation_seg_sign.sv | 26 ++
 rtl/modulation_unroll_mapper.sv | 130 +++++++++++++
 tb/tb_modulation_unroll_mapper.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/modulation_pkg.sv
// -----------------------------------------------------------------------------
// modulation_pkg
// Shared constants and encodings for the Modulation_Unroll datapath.
//   ONE_Q16 / MINUS_ONE_Q16 : +1.0 and -1.0 in Q16.16
//   mode_e                  : input word interpretation (direct / differential)
// -----------------------------------------------------------------------------
package modulation_pkg;

  localparam logic [31:0] ONE_Q16       = 32'h0001_0000;
  localparam logic [31:0] MINUS_ONE_Q16 = 32'hFFFF_0000;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_DIFF   = 1'b1
  } mode_e;

endpackage : modulation_pkg

// File: rtl/modulation_seg_sign.sv
// -----------------------------------------------------------------------------
// modulation_seg_sign
// Combinational sign selector for one output segment.
//   d_i   : data bit for this segment (after differential coding)
//   pol_i : polarity inversion bit for this segment
//   amp_i : segment magnitude (two's complement, DATA_W bits)
//   seg_o : +amp when (d ^ pol) = 1, otherwise -amp (wraps, no saturation)
// -----------------------------------------------------------------------------
module modulation_seg_sign #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              d_i,
  input  logic              pol_i,
  input  logic [DATA_W-1:0] amp_i,
  output logic [DATA_W-1:0] seg_o
);

  logic              sign_s;
  logic [DATA_W-1:0] neg_amp_s;

  // Negation is truncated to DATA_W, so the most negative amp maps to itself.
  assign neg_amp_s = ~amp_i + {{(DATA_W-1){1'b0}}, 1'b1};
  assign sign_s    = d_i ^ pol_i;
  assign seg_o     = sign_s ? amp_i : neg_amp_s;

endmodule : modulation_seg_sign

// File: rtl/modulation_unroll_mapper.sv
// -----------------------------------------------------------------------------
// modulation_unroll_mapper
// Maps one input bit word onto NUM_SEG signed segments of +amp / -amp, with
// optional differential (DBPSK) coding whose phase carries across words.
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake; in_bits, mode, amp, clear_phase
//                       are sampled on accept
//   out_valid/out_ready, out_segs : registered output handshake and segments
//                       (segment k at [k*DATA_W +: DATA_W])
//   word_cnt          : wrapping count of accepted input words
// -----------------------------------------------------------------------------
module modulation_unroll_mapper
  import modulation_pkg::*;
#(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         NUM_SEG  = 10,
  parameter int unsigned         BIT_W    = 32,
  parameter logic [NUM_SEG-1:0]  POL_MASK = {NUM_SEG{1'b0}},
  parameter int unsigned         CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIT_W-1:0]          in_bits,
  input  logic                      mode,
  input  logic [DATA_W-1:0]         amp,
  input  logic                      clear_phase,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_SEG*DATA_W-1:0] out_segs,
  output logic [CNT_W-1:0]          word_cnt
);

  logic                      out_valid_q, out_valid_d;
  logic [NUM_SEG*DATA_W-1:0] out_segs_q,  out_segs_d;
  logic                      phase_q,     phase_d;
  logic [CNT_W-1:0]          cnt_q,       cnt_d;

  logic                      accept_s;
  logic                      is_diff_s;
  logic [NUM_SEG-1:0]        d_s;
  logic [NUM_SEG*DATA_W-1:0] seg_s;

  // Bits at index NUM_SEG and above carry no meaning for this block.
  logic unused_bits_s;
  assign unused_bits_s = ^in_bits;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign is_diff_s = (mode_e'(mode) == MODE_DIFF);

  // Differential chain: each bit is XORed with the previous coded bit,
  // seeded by the stored phase (or 0 when clear_phase is asserted).
  always_comb begin
    logic prev_s;
    d_s    = '0;
    prev_s = clear_phase ? 1'b0 : phase_q;
    for (int k = 0; k < int'(NUM_SEG); k++) begin
      if (is_diff_s) begin
        d_s[k] = in_bits[k] ^ prev_s;
      end else begin
        d_s[k] = in_bits[k];
      end
      prev_s = d_s[k];
    end
  end

  for (genvar g = 0; g < int'(NUM_SEG); g++) begin : g_seg
    modulation_seg_sign #(
      .DATA_W (DATA_W)
    ) u_seg_sign (
      .d_i   (d_s[g]),
      .pol_i (POL_MASK[g]),
      .amp_i (amp),
      .seg_o (seg_s[g*DATA_W +: DATA_W])
    );
  end

  // Next-state for the output register, phase and counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_segs_d  = out_segs_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_segs_d  = seg_s;
      cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (is_diff_s) begin
        phase_d = d_s[NUM_SEG-1];
      end else if (clear_phase) begin
        phase_d = 1'b0;
      end else begin
        phase_d = phase_q;
      end
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (clear_phase) begin
        phase_d = 1'b0;
      end else begin
        phase_d = phase_q;
      end
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_segs_q  <= '0;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_segs_q  <= out_segs_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_segs  = out_segs_q;
  assign word_cnt  = cnt_q;

endmodule : modulation_unroll_mapper

// File: tb/tb_modulation_unroll_mapper.sv
module tb_modulation_unroll_mapper;
  import modulation_pkg::*;

  localparam logic [9:0] POL_B = 10'b0000100110;

  logic         clk = 1'b0;
  logic         reset, in_valid, mode, clear_phase, out_ready;
  logic [31:0]  in_bits, amp;
  logic         in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [319:0] out_segs_a, out_segs_b;
  logic [15:0]  word_cnt_a;
  logic [3:0]   word_cnt_b;

  always #5 clk = ~clk;

  modulation_unroll_mapper dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_bits(in_bits), .mode(mode), .amp(amp), .clear_phase(clear_phase),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_segs(out_segs_a),
    .word_cnt(word_cnt_a)
  );

  modulation_unroll_mapper #(.POL_MASK(POL_B), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_bits(in_bits), .mode(mode), .amp(amp), .clear_phase(clear_phase),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_segs(out_segs_b),
    .word_cnt(word_cnt_b)
  );

  typedef struct {
    logic        rst, vld, md, clr;
    logic [31:0] bits, a;
    logic        rdy, chk;
    logic [9:0]  sign;  // hand-derived coded bits for dut_a when chk=1
  } vec_t;

  typedef struct {
    logic [319:0] segs_a, segs_b;
  } exp_t;

  exp_t       sb[$];
  logic       m_phase;
  logic [15:0] m_cnt_a;
  logic [3:0]  m_cnt_b;
  int         n_cmp = 0, n_bad = 0;

  function automatic logic [9:0] model_d(input logic [31:0] bits, input logic md,
                                         input logic seed);
    logic [9:0] d;
    logic p;
    p = seed;
    for (int k = 0; k < 10; k++) begin
      d[k] = md ? (bits[k] ^ p) : bits[k];
      p = d[k];
    end
    return d;
  endfunction

  function automatic logic [319:0] build(input logic [9:0] d, input logic [9:0] pol,
                                         input logic [31:0] a);
    logic [319:0] r;
    for (int k = 0; k < 10; k++)
      r[k*32 +: 32] = (d[k] ^ pol[k]) ? a : (32'd0 - a);
    return r;
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic rst, vld, md, clr, input logic [31:0] bits, a,
                       input logic rdy, chk, input logic [9:0] sign);
    logic exp_ready;
    logic seed;
    logic [9:0] d;
    exp_t e;
    reset = rst; in_valid = vld; mode = md; clear_phase = clr;
    in_bits = bits; amp = a; out_ready = rdy;
    #1;
    exp_ready = (sb.size() == 0) || rdy;
    if (!rst) begin
      check("in_ready_a", {319'd0, in_ready_a}, {319'd0, exp_ready});
      check("in_ready_b", {319'd0, in_ready_b}, {319'd0, exp_ready});
    end
    if (rst) begin
      sb.delete();
      m_phase = 1'b0; m_cnt_a = 16'd0; m_cnt_b = 4'd0;
    end else begin
      if (sb.size() != 0 && rdy) void'(sb.pop_front());
      if (vld && exp_ready) begin
        seed = clr ? 1'b0 : m_phase;
        d = model_d(bits, md, seed);
        e.segs_a = build(chk ? sign : d, 10'd0, a);
        e.segs_b = build(d, POL_B, a);
        sb.push_back(e);
        m_cnt_a = m_cnt_a + 16'd1;
        m_cnt_b = m_cnt_b + 4'd1;
        if (md) m_phase = d[9];
        else if (clr) m_phase = 1'b0;
      end else if (clr) begin
        m_phase = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid_a", {319'd0, out_valid_a}, {319'd0, sb.size() != 0});
    check("out_valid_b", {319'd0, out_valid_b}, {319'd0, sb.size() != 0});
    check("word_cnt_a", {304'd0, word_cnt_a}, {304'd0, m_cnt_a});
    check("word_cnt_b", {316'd0, word_cnt_b}, {316'd0, m_cnt_b});
    if (sb.size() != 0) begin
      check("segs_a", out_segs_a, sb[0].segs_a);
      check("segs_b", out_segs_b, sb[0].segs_b);
    end else if (rst) begin
      check("segs_a_reset", out_segs_a, 320'd0);
      check("segs_b_reset", out_segs_b, 320'd0);
    end
  endtask

  vec_t vecs[21];

  initial begin
    //          rst   vld   md    clr   bits           amp            rdy   chk   sign
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         ONE_Q16,       1'b0, 1'b0, 10'h000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h3,         ONE_Q16,       1'b1, 1'b1, 10'h003};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h001,       ONE_Q16,       1'b1, 1'b1, 10'h3FF};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h000,       ONE_Q16,       1'b1, 1'b1, 10'h3FF};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h002,       ONE_Q16,       1'b1, 1'b1, 10'h001};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h000,       ONE_Q16,       1'b1, 1'b1, 10'h000};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h001,       ONE_Q16,       1'b1, 1'b1, 10'h3FF};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h000,       ONE_Q16,       1'b1, 1'b1, 10'h000};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h000,       ONE_Q16,       1'b1, 1'b1, 10'h000};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h3FF,       ONE_Q16,       1'b1, 1'b1, 10'h3FF};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFC00,  ONE_Q16,       1'b1, 1'b1, 10'h000};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h155,       32'h0,         1'b1, 1'b1, 10'h155};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0AA,       32'h80000000,  1'b1, 1'b1, 10'h0AA};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h2C1,       32'h00012345,  1'b1, 1'b1, 10'h2C1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h3FF,       ONE_Q16,       1'b1, 1'b1, 10'h155};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h200,       ONE_Q16,       1'b1, 1'b1, 10'h200};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h000,       ONE_Q16,       1'b1, 1'b1, 10'h000};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h000,       ONE_Q16,       1'b1, 1'b1, 10'h3FF};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h000,       ONE_Q16,       1'b1, 1'b0, 10'h000};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h000,       ONE_Q16,       1'b1, 1'b1, 10'h000};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h000,       ONE_Q16,       1'b1, 1'b0, 10'h000};

    m_phase = 1'b0; m_cnt_a = 16'd0; m_cnt_b = 4'd0;
    @(negedge clk);

    for (int i = 0; i < 21; i++)
      cycle(vecs[i].rst, vecs[i].vld, vecs[i].md, vecs[i].clr, vecs[i].bits,
            vecs[i].a, vecs[i].rdy, vecs[i].chk, vecs[i].sign);

    // Backpressure: held word stays stable, no accept until out_ready returns.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0F0, ONE_Q16, 1'b1, 1'b1, 10'h0F0);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h00F, ONE_Q16, 1'b0, 1'b0, 10'h000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h00F, ONE_Q16, 1'b1, 1'b1, 10'h00F);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h000, ONE_Q16, 1'b1, 1'b0, 10'h000);

    // Reset while a word is stalled, with phase previously set to 1.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h001, ONE_Q16, 1'b1, 1'b1, 10'h3FF);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h000, ONE_Q16, 1'b0, 1'b0, 10'h000);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h000, ONE_Q16, 1'b0, 1'b0, 10'h000);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h000, ONE_Q16, 1'b1, 1'b1, 10'h000);

    // Counter wrap: 17 accepts from reset leave the 4-bit counter at 1.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h000, ONE_Q16, 1'b1, 1'b0, 10'h000);
    for (int i = 0; i < 17; i++)
      cycle(1'b0, 1'b1, 1'b0, 1'b0, $urandom, $urandom, 1'b1, 1'b0, 10'h000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h000, ONE_Q16, 1'b1, 1'b0, 10'h000);
    check("cnt_wrap_b", {316'd0, word_cnt_b}, 320'd1);
    check("cnt_17_a", {304'd0, word_cnt_a}, 320'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_modulation_unroll_mapper
